// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with an integrated baud-tick generator and
// 16x oversampling. It rejects start glitches, checks the stop bit, and holds
// off in a break state while the line stays low after a framing error. A
// synchronous clear aborts the current frame and zeroes the data register.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 163
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic                 i_rx_clear,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_ready,
    output logic                 o_frame_error,
    output logic                 o_busy
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0]    S_MID     = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    S_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 tick_s;
    state_e               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    assign rx_s   = sync_q[1];
    assign tick_s = (tick_cnt_q == TICK_LAST);

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    // Next-state logic: tick counter, oversample/bit counters, shifter and strobes.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_s ? '0 : tick_cnt_q + 1'b1;
        s_cnt_d    = s_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        ferr_d     = 1'b0;

        if (i_rx_clear) begin
            // Abort wins over everything, including a coincident stop sample.
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            s_cnt_d    = 4'd0;
            bit_cnt_d  = '0;
            shreg_d    = '0;
            data_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        s_cnt_d    = 4'd0;
                        tick_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_s && (s_cnt_q == S_MID)) begin
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            s_cnt_d   = 4'd0;
                            bit_cnt_d = '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_d = ST_IDLE;
                        end
                    end else if (tick_s) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end else begin
                        s_cnt_d = s_cnt_q;
                    end
                end
                ST_DATA: begin
                    if (tick_s && (s_cnt_q == S_LAST)) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d = 4'd0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else if (tick_s) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end else begin
                        s_cnt_d = s_cnt_q;
                    end
                end
                ST_STOP: begin
                    if (tick_s && (s_cnt_q == S_LAST)) begin
                        s_cnt_d = 4'd0;
                        if (rx_s) begin
                            data_d  = shreg_q;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else if (tick_s) begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end else begin
                        s_cnt_d = s_cnt_q;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must not retrigger reception.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Receiver FSM state, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            s_cnt_q    <= 4'd0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            s_cnt_q    <= s_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign o_rx_data     = data_q;
    assign o_rx_ready    = ready_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with CLK_DIV=2 (32 clocks per bit).
module tb_uart_rx;

    localparam int BIT_CLKS = 32;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       clr;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_error;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [7:0] last_good = 8'h00;
    logic prev_strobe = 1'b0;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .CLK_DIV   (2)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_rx         (rx),
        .i_rx_clear   (clr),
        .o_rx_data    (rx_data),
        .o_rx_ready   (rx_ready),
        .o_frame_error(frame_error),
        .o_busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h expected=%0h at cyc %0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard on every strobe and compare kind, data, timing.
    always @(negedge clk) begin
        exp_t e;
        if (rx_ready || frame_error) begin
            check("strobe_gap", {31'd0, prev_strobe}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, frame_error, rx_ready}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {30'd0, frame_error, rx_ready}, e.err ? 32'd2 : 32'd1);
                check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
                check("strobe_cycle", cyc, e.cyc);
            end
        end
        prev_strobe = rx_ready | frame_error;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the next posedge is edge 0, the strobe follows edge 306.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit push, input bit is_err);
        exp_t e;
        if (push) begin
            e.err  = is_err;
            e.data = is_err ? last_good : d;
            e.cyc  = cyc + 307;
            sb.push_back(e);
            if (!is_err) last_good = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
    endtask

    initial begin
        rx    = 1'b1;
        clr   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_ready", {31'd0, rx_ready}, 32'd0);
        check("reset_ferr", {31'd0, frame_error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 1. good byte
        send_frame(8'h73, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("good_byte_data", {24'd0, rx_data}, 32'h73);

        // 2. back-to-back stream, no gaps
        send_frame(8'h69, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        send_frame(8'h08, 1'b1, 1'b1, 1'b0);
        idle(20);

        // 3. start glitch of 6 clocks
        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("glitch_busy_during", {31'd0, busy}, 32'd1);
        idle(30);
        check("glitch_busy_after", {31'd0, busy}, 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(20);

        // 4. framing error, break hold, then recovery
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        check("break_busy_1", {31'd0, busy}, 32'd1);
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        check("break_busy_2", {31'd0, busy}, 32'd1);
        check("break_data_held", {24'd0, rx_data}, 32'hA5);
        idle(BIT_CLKS);
        check("break_released", {31'd0, busy}, 32'd0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("after_break_data", {24'd0, rx_data}, 32'h55);

        // 5. clear during data bit 4
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                repeat (170) @(posedge clk);
                #1;
                clr = 1'b1;
                @(posedge clk);
                #1;
                clr = 1'b0;
                @(posedge clk);
                #1;
                check("clear_data", {24'd0, rx_data}, 32'd0);
                check("clear_busy", {31'd0, busy}, 32'd0);
            end
        join
        last_good = 8'h00;
        idle(20);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        idle(20);

        // 6. async reset during bit 2
        fork
            send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
            begin
                repeat (106) @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                check("areset_data", {24'd0, rx_data}, 32'd0);
                check("areset_ready", {31'd0, rx_ready}, 32'd0);
                check("areset_ferr", {31'd0, frame_error}, 32'd0);
                check("areset_busy", {31'd0, busy}, 32'd0);
            end
        join
        idle(3);
        rst_n = 1'b1;
        idle(5);
        last_good = 8'h00;
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        idle(20);

        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding the debug unit's byte interface. It converts the host's 8N1 UART stream into one-cycle `o_rx_ready` strobes with a parallel byte: the debug FSM reads them as commands ('s', 'i', 'c') and as instruction-memory bytes. It has an integrated baud-tick generator, 16x oversampling, start-glitch rejection, stop-bit framing check, and a synchronous clear driven by the debug unit's `o_uart_rx_reset`.

## Interface
- `DATA_BITS`, 8, payload bits per frame (LSB first).
- `OVERSAMPLE`, 16, sample ticks per bit; fixed at 16, and `s_cnt` is 4 bits.
- `CLK_DIV`, 163, clocks per sample tick. 50 MHz / (19200 × 16) is about 163.
- `i_clk` input 1: system clock, single domain.
- `i_reset_n` input 1: asynchronous reset, active-low.
- `i_rx` input 1: asynchronous serial line, idles high.
- `i_rx_clear` input 1: synchronous abort of the current frame. Connects to the debug `o_uart_rx_reset`.
- `o_rx_data` output DATA_BITS: last good byte. It holds until the next good byte or a clear.
- `o_rx_ready` output 1: one-cycle strobe meaning `o_rx_data` is newly valid.
- `o_frame_error` output 1: one-cycle strobe meaning the stop bit sampled low.
- `o_busy` output 1: high in every state except IDLE.

## Operation
- `i_rx` passes through a 2-FF synchronizer before any use. Both flops reset to 1. Its output is `rx_s`.
- Tick generator `tick_cnt` counts 0..CLK_DIV-1.
  - `tick` is combinational and true when `tick_cnt == CLK_DIV-1`.
  - The counter wraps to 0 after `CLK_DIV-1`.
  - It is forced to 0 on the IDLE→START transition.
- State machine:
  - **IDLE**: when `rx_s == 0`, go to START; clear `s_cnt` and `tick_cnt`.
  - **START**: on each tick, if `s_cnt == 7`:
    - If `rx_s == 0`, go to DATA with `s_cnt = 0` and `bit_cnt = 0`.
    - Otherwise it was a glitch: go to IDLE with no strobe.
    - If `s_cnt != 7`, increment `s_cnt`.
  - **DATA**: on each tick, if `s_cnt == 15`:
    - Shift `shreg <= {rx_s, shreg[DATA_BITS-1:1]}` and set `s_cnt = 0`.
    - If `bit_cnt == DATA_BITS-1`, go to STOP; otherwise increment `bit_cnt`.
    - If `s_cnt != 15`, increment `s_cnt`.
  - **STOP**: on a tick with `s_cnt == 15`:
    - If `rx_s == 1`: set `o_rx_data <= shreg`, pulse `o_rx_ready`, go to IDLE.
    - Otherwise: pulse `o_frame_error`, discard `shreg` (leave `o_rx_data` unchanged), go to BREAK.
  - **BREAK**: wait for `rx_s == 1`, then go to IDLE. This stops a held-low line (break) from retriggering reception.
- `i_rx_clear` has priority over every other event in the same cycle:
  - `state = IDLE`; `s_cnt`, `bit_cnt`, `tick_cnt`, `shreg` and `o_rx_data` all go to 0.
  - No strobe is issued in that cycle or for the aborted frame.
  - A frame whose stop sample coincides with the clear is dropped.
- `o_rx_ready` and `o_frame_error` are registered. They are never high together and never high for two consecutive cycles.

## Timing
- Reset (`i_reset_n` low, asynchronous):
  - State is IDLE.
  - All counters and `shreg` are 0.
  - `o_rx_data = 0`, `o_rx_ready = 0`, `o_frame_error = 0`, `o_busy = 0`.
  - Synchronizer flops are 1.
- Edge numbering: edge 0 is the first clock edge that samples `i_rx` low.
  - START is entered at edge 2.
  - The Nth tick is consumed at edge 2 + N·CLK_DIV.
- Start validation happens at tick 8, the mid-bit point.
- Data bit k (k from 0) is sampled at tick 8 + 16·(k+1).
- Stop bit is sampled at tick 8 + 16·(DATA_BITS+1), which is tick 152 for 8 bits.
- `o_rx_ready` / `o_frame_error` are high for exactly the one cycle after edge 2 + (8 + 16·(DATA_BITS+1))·CLK_DIV.
- `o_busy` rises after edge 2 and falls in the same cycle the strobe is high, unless the next state is BREAK.
- Back-to-back frames:
  - After the stop sample, IDLE is reached half a bit early.
  - A start edge arriving at the nominal stop-bit end is detected normally.
  - No inter-frame gap is required.
- The consumer must take the byte in the strobe cycle. There is no backpressure and no FIFO; an unread byte is overwritten by the next one.

## Test plan
All scenarios use CLK_DIV=2 (32 clocks per bit).
1. **Good byte.** Send 8N1 frame 0x73 ('s'). Required: `o_rx_data = 0x73`, `o_rx_ready` high for 1 cycle exactly after edge 306, `o_frame_error` stays 0.
2. **Back-to-back stream.** Send 0x69, 0x00, 0x00, 0x00, 0x08 with no idle gaps. Required: 5 strobes in that order, 320 clocks apart, with the correct data each time.
3. **Start glitch.** Pull `i_rx` low for 6 clocks, then release. Required: returns to IDLE after tick 8 with no strobe and `o_busy` low. A following 0xA5 frame is received correctly.
4. **Framing error and break.** Send 0x3C with stop bit 0, then hold the line low for 2 bit times, then send 0x55.
   - `o_frame_error` pulses once.
   - `o_rx_data` keeps its old value.
   - There is no restart while the line is low.
   - 0x55 is then received.
5. **Clear mid-frame.** Assert `i_rx_clear` for 1 cycle during data bit 4 of 0xFF.
   - No strobe for that frame.
   - `o_rx_data = 0`; the state is IDLE or BREAK-free IDLE.
   - The next frame 0x12 is received.
6. **Async reset mid-frame.** Pull `i_reset_n` low during bit 2. Required: all outputs are at their reset values immediately (before the next clock edge). After release, 0xC3 is received correctly.
